fft_mag_frame_rx: RTL and testbench
===================================

// Module: fft_mag_frame_rx
// PURPOSE
// - Receive end of the FFT output stream: consumes complex FFT frames (FFT_CHANNELS lanes) and emits |X|^2 per bin.
// - Enforces FFT_LEN-beat framing and reports one status word per frame (length and tlast errors).
// - Sits between the FFT core output and the packet/ethernet formatter.
// PARAMETERS
// - FFT_LEN              8192  bins per frame (power of 2, 16..65536)
// - FFT_CHANNELS         2     parallel lanes per beat
// - FFT_AXI_DATA_WIDTH   32    bits per lane in and out (in {im[31:16],re[15:0]} signed; out unsigned)
// PORTS
// - aclk            in   1     clock; single clock domain
// - areset          in   1     synchronous, active-high reset
// - s_axis_tdata    in   FFT_CHANNELS*32  complex bins, lane c = [32c+31:32c]
// - s_axis_tvalid   in   1     input valid
// - s_axis_tlast    in   1     input end of frame
// - s_axis_tready   out  1     input ready
// - m_axis_tdata    out  FFT_CHANNELS*32  |X|^2 per lane
// - m_axis_tvalid   out  1     output valid
// - m_axis_tlast    out  1     output end of frame
// - m_axis_tready   in   1     output ready
// - frame_enable    in   1     level; arms capture of next frame
// - stat_valid      out  1     1-cycle pulse, frame status
// - stat_tdata      out  32    [31] tlast early, [30] tlast missing, [29:24] 0, [23:0] input beats consumed
// - frame_count     out  16    completed frames, wraps at 0xFFFF->0
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, pipeline valids cleared; partial frame dropped, no status emitted.
// - FSM: IDLE, RUN, DISCARD, DRAIN, STATUS.
// - IDLE: s_axis_tready=0; frame_enable=1 -> RUN, bin counter cleared.
// - RUN: s_axis_tready=en; each accepted beat enters pipeline, bin++ (counter width clogb2(FFT_LEN)+1).
//   - accepted tlast with bin<FFT_LEN-1: early=1, beat tagged last -> DRAIN.
//   - accepted beat at bin==FFT_LEN-1 with tlast: tagged last -> DRAIN.
//   - accepted beat at bin==FFT_LEN-1 without tlast: missing=1, tagged last -> DISCARD.
// - DISCARD: s_axis_tready=1; beats dropped (not in pipeline), beat count still increments; accepted tlast -> DRAIN.
// - DRAIN: s_axis_tready=0; wait until tagged-last beat handshakes on m_axis (sticky flag; may already be set) -> STATUS.
// - STATUS: one cycle; stat_valid=1 with stat_tdata; frame_count++; flags cleared -> IDLE.
// - Beat count saturates at 0xFFFFFF.
// - Pipeline: 2 stages, global enable en = !(v2 & !m_axis_tready); s_axis_tready combinational from en and state.
//   - stage1: re*re, im*im signed 16x16 -> 32b registered; stage2: unsigned 32b sum, no overflow (max 2^31).
//   - latency: input handshake -> m_axis_tvalid 2 cycles when unstalled; full throughput 1 beat/cycle.
//   - m_axis_tvalid held, tdata/tlast stable until m_axis_tready; no beat lost or duplicated under backpressure.
// - m_axis_tlast=1 on exactly one beat per frame: the tagged-last beat.
// - Simultaneous s handshake and m handshake in same cycle: both take effect, pipeline shifts.
// - frame_enable deasserted mid-frame: ignored until STATUS; sampled only in IDLE.
// STRUCTURE
// - Package fft_pkg: FSM state encodings, clogb2(), stat_tdata field offsets, lane re/im bit offsets.
// - Sub-module cmag_sq_pipe: one lane, 2-stage |X|^2 with enable; instantiated FFT_CHANNELS times via generate.
// - Top holds FSM, bin/beat counters, last-tag pipeline bit, status register, frame_count.
// TESTING (FFT_LEN=16 for bench)
// - Clean frame: 16 beats, each lane re=3, im=4, tlast on beat 16 -> 16 outputs 0x00000019, tlast on 16th, stat 0x00000010.
// - Extremes: re=-32768, im=-32768 -> 0x80000000; re=32767, im=0 -> 0x3FFF0001.
// - Early tlast on beat 10 -> 10 outputs, tlast on 10th, stat_tdata 0x8000000A, frame_count +1.
// - Missing tlast, tlast on beat 20 -> 16 outputs, tlast on 16th, 4 beats dropped, stat_tdata 0x40000014.
// - m_axis_tready random 50% over 3 back-to-back frames, frame_enable held 1 -> outputs in order, none lost or duplicated.
// - areset at beat 7 -> next cycle all outputs 0, no stat_valid; following frame clean, frame_count 1.

Source files
------------

// File: rtl/fft_mag_frame_rx_pkg.sv
// Shared types and field layout for the FFT magnitude frame receiver.
// Holds FSM states, lane re/im offsets, status word offsets and clogb2().
package fft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DISCARD = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_STATUS  = 3'd4
    } state_e;

    localparam int LANE_W  = 32;
    localparam int PART_W  = 16;
    localparam int RE_LSB  = 0;
    localparam int IM_LSB  = 16;

    localparam int STAT_W           = 32;
    localparam int STAT_EARLY_BIT   = 31;
    localparam int STAT_MISSING_BIT = 30;
    localparam int STAT_BEATS_W     = 24;

    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fft_mag_frame_rx_cmag_sq_pipe.sv
// One lane of |X|^2: stage 1 squares re and im, stage 2 sums them.
// Both stages advance only when en is high so a stalled output holds still.
module cmag_sq_pipe
    import fft_pkg::*;
(
    input  logic              aclk,
    input  logic              areset,
    input  logic              en,
    input  logic [LANE_W-1:0] in_data,
    output logic [LANE_W-1:0] mag
);

    logic signed [PART_W-1:0] re, im;
    logic signed [LANE_W-1:0] re_x, im_x, re_sq, im_sq;
    logic [LANE_W-1:0] re_sq_d, re_sq_q, im_sq_d, im_sq_q, mag_d, mag_q;

    assign re    = in_data[RE_LSB +: PART_W];
    assign im    = in_data[IM_LSB +: PART_W];
    assign re_x  = {{(LANE_W-PART_W){re[PART_W-1]}}, re};
    assign im_x  = {{(LANE_W-PART_W){im[PART_W-1]}}, im};
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;

    // Squares are at most 2^30 each, so the unsigned sum never wraps.
    always_comb begin
        re_sq_d = re_sq_q;
        im_sq_d = im_sq_q;
        mag_d   = mag_q;
        if (en) begin
            re_sq_d = re_sq;
            im_sq_d = im_sq;
            mag_d   = re_sq_q + im_sq_q;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            re_sq_q <= '0;
            im_sq_q <= '0;
            mag_q   <= '0;
        end else begin
            re_sq_q <= re_sq_d;
            im_sq_q <= im_sq_d;
            mag_q   <= mag_d;
        end
    end

    assign mag = mag_q;

endmodule

// File: rtl/fft_mag_frame_rx.sv
// FFT output receiver: per-lane |X|^2 with FFT_LEN-beat framing enforcement
// and one status word per frame reporting early/missing tlast and beat count.
module fft_mag_frame_rx
    import fft_pkg::*;
#(
    parameter int FFT_LEN            = 8192,
    parameter int FFT_CHANNELS       = 2,
    parameter int FFT_AXI_DATA_WIDTH = 32
) (
    input  logic                                       aclk,
    input  logic                                       areset,
    input  logic [FFT_CHANNELS*FFT_AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                                       s_axis_tvalid,
    input  logic                                       s_axis_tlast,
    output logic                                       s_axis_tready,
    output logic [FFT_CHANNELS*FFT_AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                                       m_axis_tvalid,
    output logic                                       m_axis_tlast,
    input  logic                                       m_axis_tready,
    input  logic                                       frame_enable,
    output logic                                       stat_valid,
    output logic [STAT_W-1:0]                          stat_tdata,
    output logic [15:0]                                frame_count
);

    localparam int BIN_W = clogb2(FFT_LEN) + 1;
    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(FFT_LEN - 1);

    state_e                  state_q;
    logic [BIN_W-1:0]        bin_q;
    logic [STAT_BEATS_W-1:0] beats_q, beats_inc;
    logic                    early_q, missing_q, last_seen_q;
    logic                    stat_valid_q;
    logic [STAT_W-1:0]       stat_tdata_q, stat_word;
    logic [15:0]             frame_count_q;

    logic v1_d, v1_q, v2_d, v2_q, last1_d, last1_q, last2_d, last2_q;
    logic pipe_en, s_fire, run_fire, m_fire, at_last_bin, tag_last, last_out;

    assign pipe_en       = !(v2_q && !m_axis_tready);
    assign s_axis_tready = (state_q == ST_RUN) ? pipe_en : (state_q == ST_DISCARD);
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign run_fire      = s_fire && (state_q == ST_RUN);
    assign m_fire        = v2_q && m_axis_tready;
    assign at_last_bin   = (bin_q == BIN_LAST);
    assign tag_last      = run_fire && (s_axis_tlast || at_last_bin);
    assign last_out      = m_fire && last2_q;
    assign beats_inc     = (beats_q == '1) ? beats_q : beats_q + STAT_BEATS_W'(1);

    always_comb begin
        stat_word                                = '0;
        stat_word[STAT_EARLY_BIT]                = early_q;
        stat_word[STAT_MISSING_BIT]              = missing_q;
        stat_word[STAT_BEATS_W-1:0]              = beats_q;
    end

    always_comb begin
        v1_d    = v1_q;
        v2_d    = v2_q;
        last1_d = last1_q;
        last2_d = last2_q;
        if (pipe_en) begin
            v1_d    = run_fire;
            last1_d = tag_last;
            v2_d    = v1_q;
            last2_d = last1_q;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            last1_q <= last1_d;
            last2_q <= last2_d;
        end
    end

    for (genvar c = 0; c < FFT_CHANNELS; c++) begin : g_lane
        cmag_sq_pipe u_lane (
            .aclk    (aclk),
            .areset  (areset),
            .en      (pipe_en),
            .in_data (s_axis_tdata[c*FFT_AXI_DATA_WIDTH +: FFT_AXI_DATA_WIDTH]),
            .mag     (m_axis_tdata[c*FFT_AXI_DATA_WIDTH +: FFT_AXI_DATA_WIDTH])
        );
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            bin_q         <= '0;
            beats_q       <= '0;
            early_q       <= 1'b0;
            missing_q     <= 1'b0;
            last_seen_q   <= 1'b0;
            stat_valid_q  <= 1'b0;
            stat_tdata_q  <= '0;
            frame_count_q <= '0;
        end else begin
            // The tagged-last beat may leave the pipe before DRAIN is reached.
            if (last_out) last_seen_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (frame_enable) begin
                        state_q     <= ST_RUN;
                        bin_q       <= '0;
                        beats_q     <= '0;
                        early_q     <= 1'b0;
                        missing_q   <= 1'b0;
                        last_seen_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (run_fire) begin
                        bin_q   <= bin_q + BIN_W'(1);
                        beats_q <= beats_inc;
                        if (s_axis_tlast) begin
                            early_q <= !at_last_bin;
                            state_q <= ST_DRAIN;
                        end else if (at_last_bin) begin
                            missing_q <= 1'b1;
                            state_q   <= ST_DISCARD;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (s_fire) begin
                        beats_q <= beats_inc;
                        if (s_axis_tlast) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_seen_q || last_out) begin
                        state_q       <= ST_STATUS;
                        stat_valid_q  <= 1'b1;
                        stat_tdata_q  <= stat_word;
                        frame_count_q <= frame_count_q + 16'd1;
                    end
                end
                ST_STATUS: begin
                    state_q      <= ST_IDLE;
                    stat_valid_q <= 1'b0;
                    early_q      <= 1'b0;
                    missing_q    <= 1'b0;
                    last_seen_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tvalid = v2_q;
    assign m_axis_tlast  = last2_q;
    assign stat_valid    = stat_valid_q;
    assign stat_tdata    = stat_tdata_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_fft_mag_frame_rx.sv
// Bench for fft_mag_frame_rx at FFT_LEN=16: frame-level model predicts outputs
// and status words; a negedge process scores every output and status handshake.
module tb_fft_mag_frame_rx;

    localparam int LEN = 16;
    localparam int CH  = 2;
    localparam int DW  = CH * 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic          frame_enable = 1'b0;
    logic          stat_valid;
    logic [31:0]   stat_tdata;
    logic [15:0]   frame_count;

    int checks = 0;
    int failures = 0;
    beat_t       exp_q[$];
    logic [31:0] exp_stat[$];
    int          model_fc = 0;
    bit          chk_en = 1'b0;
    bit          rnd_ready = 1'b0;

    fft_mag_frame_rx #(
        .FFT_LEN(LEN), .FFT_CHANNELS(CH), .FFT_AXI_DATA_WIDTH(32)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .frame_enable(frame_enable), .stat_valid(stat_valid),
        .stat_tdata(stat_tdata), .frame_count(frame_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mag(input int re, input int im);
        longint r, i, s;
        r = re;
        i = im;
        s = r * r + i * i;
        return s[31:0];
    endfunction

    function automatic logic [31:0] pack_lane(input int re, input int im);
        logic [31:0] v;
        v = {im[15:0], re[15:0]};
        return v;
    endfunction

    // mode 0: every lane 3+4j; mode 1: lane0 -32768-32768j, lane1 32767; mode 2: random
    task automatic make_beat(input int mode, output logic [DW-1:0] d, output logic [DW-1:0] e);
        int re, im;
        d = '0;
        e = '0;
        case (mode)
            0: begin
                d = {pack_lane(3, 4), pack_lane(3, 4)};
                e = {32'h0000_0019, 32'h0000_0019};
            end
            1: begin
                d = {pack_lane(32767, 0), pack_lane(-32768, -32768)};
                e = {32'h3FFF_0001, 32'h8000_0000};
            end
            default: begin
                for (int c = 0; c < CH; c++) begin
                    re = int'($urandom_range(0, 65535)) - 32768;
                    im = int'($urandom_range(0, 65535)) - 32768;
                    d[c*32 +: 32] = pack_lane(re, im);
                    e[c*32 +: 32] = mag(re, im);
                end
            end
        endcase
    endtask

    // Scoreboard: every output and status handshake must match the next expectation.
    always @(negedge aclk) begin : cmp
        beat_t e;
        if (chk_en && !areset) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", {63'd0, m_axis_tvalid}, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", m_axis_tdata, e.data);
                    check("out_last", {63'd0, m_axis_tlast}, {63'd0, e.last});
                end
            end
            if (stat_valid) begin
                if (exp_stat.size() == 0)
                    check("stat_unexpected", {63'd0, stat_valid}, '0);
                else
                    check("stat_tdata", {32'd0, stat_tdata}, {32'd0, exp_stat.pop_front()});
            end
        end
    end

    always @(posedge aclk) begin
        #1;
        m_axis_tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Called in the posedge+1 phase; returns in the same phase after the handshake.
    task automatic drive_beat(input logic [DW-1:0] d, input logic l);
        int n;
        bit hs;
        n = 0;
        hs = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!hs && n < 1000) begin
            @(negedge aclk);
            hs = s_axis_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        if (!hs) check("drive_timeout", {63'd0, hs}, {63'd0, 1'b1});
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic run_frame(input int tlast_beat, input int mode, input logic [31:0] stat_lit, input bit use_lit);
        int kept;
        logic [DW-1:0] d, e;
        beat_t b;
        logic [31:0] st;
        kept = (tlast_beat < LEN) ? tlast_beat : LEN;
        st = {(tlast_beat < LEN), (tlast_beat > LEN), 6'd0, 24'(tlast_beat)};
        exp_stat.push_back(use_lit ? stat_lit : st);
        model_fc = (model_fc + 1) & 16'hFFFF;
        for (int i = 1; i <= tlast_beat; i++) begin
            make_beat(mode, d, e);
            if (i <= kept) begin
                b.data = e;
                b.last = (i == kept);
                exp_q.push_back(b);
            end
            drive_beat(d, i == tlast_beat);
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                #1;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_stat.size() != 0) && n < 3000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (n >= 3000) check({name, "_timeout"}, DW'(exp_q.size() + exp_stat.size()), '0);
        repeat (3) begin
            @(posedge aclk);
            #1;
        end
        check({name, "_frame_count"}, {48'd0, frame_count}, DW'(model_fc));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_m_tvalid"}, {63'd0, m_axis_tvalid}, '0);
        check({name, "_m_tlast"}, {63'd0, m_axis_tlast}, '0);
        check({name, "_m_tdata"}, m_axis_tdata, '0);
        check({name, "_s_tready"}, {63'd0, s_axis_tready}, '0);
        check({name, "_stat_valid"}, {63'd0, stat_valid}, '0);
        check({name, "_stat_tdata"}, {32'd0, stat_tdata}, '0);
        check({name, "_frame_count"}, {48'd0, frame_count}, '0);
    endtask

    initial begin
        logic [DW-1:0] d, e;
        beat_t b;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check_all_zero("reset");
        @(posedge aclk);
        #1;

        // Partial frame cut short by reset after beat 7.
        chk_en = 1'b1;
        frame_enable = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            make_beat(0, d, e);
            b.data = e;
            b.last = 1'b0;
            exp_q.push_back(b);
            drive_beat(d, 1'b0);
        end
        areset = 1'b1;
        chk_en = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check_all_zero("midreset");
        exp_q.delete();
        exp_stat.delete();
        model_fc = 0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        chk_en = 1'b1;

        run_frame(16, 0, 32'h0000_0010, 1'b1);
        wait_idle("clean");
        run_frame(16, 1, 32'h0000_0010, 1'b1);
        wait_idle("extreme");
        run_frame(10, 1, 32'h8000_000A, 1'b1);
        wait_idle("early");
        run_frame(20, 0, 32'h4000_0014, 1'b1);
        wait_idle("missing");

        rnd_ready = 1'b1;
        for (int f = 0; f < 3; f++) run_frame(16, 2, 32'h0, 1'b0);
        wait_idle("b2b");
        run_frame(int'($urandom_range(3, 15)), 2, 32'h0, 1'b0);
        run_frame(int'($urandom_range(17, 24)), 2, 32'h0, 1'b0);
        wait_idle("rnd_len");
        rnd_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
